// File: rtl/hart_pkg.sv
// hart_pkg: sequencer states, memory width codes and the idle instruction.
package hart_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DATA,
        S_COMMIT,
        S_HALT
    } state_t;
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
endpackage

// File: rtl/lane_steer.sv
// lane_steer: byte enables, store replication and load shift/extend for one access.
module lane_steer
    import hart_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  width,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_steer,
    output logic [31:0] rdata_ext
);
    logic [31:0] sh;
    // width[1] covers both the word code and the unused code 3
    always_comb begin
        sh = rdata >> {addr, 3'b000};
        be = width[1] ? 4'hF << addr : width == W_HALF ? 4'h3 << addr : 4'h1 << addr;
        wdata_steer = width[1] ? wdata : width == W_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        rdata_ext = width[1] ? sh : width == W_HALF ? {{16{sext & sh[15]}}, sh[15:0]}
                                                    : {{24{sext & sh[7]}}, sh[7:0]};
    end
endmodule

// File: rtl/hart_sequencer.sv
// hart_sequencer: multi-cycle fetch/exec/data sequencer sharing one bus for the hart.
// Define HART_SEQ_MISALIGN_CHECK_EN to trap misaligned accesses and branch targets into HALT.
module hart_sequencer
    import hart_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [31:0] pc,
    output logic [31:0] insn,
    input  logic [31:0] nextpc,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwdata,
    input  logic        memw,
    input  logic        hart_load,
    input  logic [1:0]  memwidth,
    input  logic        memsext,
    output logic [31:0] memrdata,
    output logic        commit,
    output logic [31:0] instret,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    state_t      state;
    logic [31:0] a, wd, sw, ld;
    logic [1:0]  w;
    logic        sx, we, mem, bad;
    logic [3:0]  be;

    assign mem = memw | hart_load;
`ifdef HART_SEQ_MISALIGN_CHECK_EN
    assign bad = mem ? ((memwidth == W_HALF && memaddr[0]) || (memwidth[1] && memaddr[1:0] != 2'b00))
                     : (nextpc[1:0] != 2'b00);
`else
    assign bad = 1'b0;
`endif

    lane_steer u_steer (
        .addr(a[1:0]),
        .width(w),
        .sext(sx),
        .wdata(wd),
        .rdata(bus_rdata),
        .be(be),
        .wdata_steer(sw),
        .rdata_ext(ld)
    );

    assign commit    = (state == S_EXEC && !mem && !bad) || state == S_COMMIT;
    assign bus_req   = state == S_FETCH || state == S_DATA;
    assign bus_we    = state == S_DATA && we;
    assign bus_addr  = state == S_DATA ? {a[31:2], 2'b00} : state == S_FETCH ? {pc[31:2], 2'b00} : 32'h0;
    assign bus_be    = state == S_DATA ? be : state == S_FETCH ? 4'hF : 4'h0;
    assign bus_wdata = bus_we ? sw : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            insn     <= NOP_INSN;
            instret  <= 32'h0;
            fault    <= 1'b0;
            memrdata <= 32'h0;
            a        <= 32'h0;
            wd       <= 32'h0;
            w        <= W_BYTE;
            sx       <= 1'b0;
            we       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (run) state <= S_FETCH;
                S_FETCH: if (bus_ready) begin
                    insn  <= bus_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: if (bad) begin
                    fault <= 1'b1;
                    state <= S_HALT;
                end else if (mem) begin
                    a     <= memaddr;
                    wd    <= memwdata;
                    w     <= memwidth;
                    sx    <= memsext;
                    we    <= memw;
                    state <= S_DATA;
                end else begin
                    pc      <= nextpc;
                    instret <= instret + 32'd1;
                    state   <= run ? S_FETCH : S_IDLE;
                    if (!run) insn <= NOP_INSN;
                end
                S_DATA: if (bus_ready) begin
                    if (!we) memrdata <= ld;
                    state <= S_COMMIT;
                end
                S_COMMIT: begin
                    pc      <= nextpc;
                    instret <= instret + 32'd1;
                    state   <= run ? S_FETCH : S_IDLE;
                    if (!run) insn <= NOP_INSN;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hart_sequencer.sv
// tb_hart_sequencer: directed scoreboard bench for hart_sequencer; expected bus transfers are queued when set up.
module tb_hart_sequencer;
    logic        clk = 0;
    logic        reset, run;
    logic [31:0] pc, insn, nextpc, memaddr, memwdata, memrdata, instret;
    logic        memw, hart_load, memsext, commit, fault;
    logic [1:0]  memwidth;
    logic        bus_req, bus_we, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;
    bus_t exp_q[$];
    int passed = 0;
    int total = 0;

    hart_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .pc(pc), .insn(insn), .nextpc(nextpc),
        .memaddr(memaddr), .memwdata(memwdata), .memw(memw), .hart_load(hart_load),
        .memwidth(memwidth), .memsext(memsext), .memrdata(memrdata), .commit(commit),
        .instret(instret), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Waits (bounded) for a request, checks it against the queue head every cycle it is held.
    task automatic serve(input int waits, input logic [31:0] rd);
        bus_t e;
        int n = 0;
        while (!bus_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'h0, bus_req}, 32'h1);
        chk("q_nonempty", {31'h0, exp_q.size() != 0}, 32'h1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i <= waits; i++) begin
                chk("req_held", {31'h0, bus_req}, 32'h1);
                chk("we", {31'h0, bus_we}, {31'h0, e.we});
                chk("addr", bus_addr, e.addr);
                chk("be", {28'h0, bus_be}, {28'h0, e.be});
                if (e.we) chk("wdata", bus_wdata, e.wdata);
                chk("no_commit_in_xfer", {31'h0, commit}, 32'h0);
                if (i == waits) begin
                    bus_ready = 1;
                    bus_rdata = rd;
                end
                @(negedge clk);
            end
        end
        bus_ready = 0;
        bus_rdata = 32'h0;
    endtask

    initial begin
        reset = 1; run = 0; nextpc = 0; memaddr = 0; memwdata = 0; memw = 0;
        hart_load = 0; memwidth = 0; memsext = 0; bus_ready = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_insn", insn, 32'h0000_0013);
        chk("rst_instret", instret, 32'h0);
        chk("rst_req", {31'h0, bus_req}, 32'h0);
        chk("rst_commit", {31'h0, commit}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_memrdata", memrdata, 32'h0);
        reset = 0; run = 1;
        @(negedge clk);
        // addi at pc 0, zero wait
        nextpc = 32'h4;
        exp_q.push_back('{1'b0, 32'h0, 4'hF, 32'h0});
        serve(0, 32'h0050_0093);
        chk("i1_commit", {31'h0, commit}, 32'h1);
        chk("i1_insn", insn, 32'h0050_0093);
        chk("i1_pc_exec", pc, 32'h0);
        @(negedge clk);
        chk("i1_pc", pc, 32'h4);
        chk("i1_instret", instret, 32'h1);
        chk("i1_commit_once", {31'h0, commit}, 32'h0);
        // fetch with 3 wait cycles
        nextpc = 32'h8;
        exp_q.push_back('{1'b0, 32'h4, 4'hF, 32'h0});
        serve(3, 32'h0010_8113);
        chk("i2_commit", {31'h0, commit}, 32'h1);
        chk("i2_insn", insn, 32'h0010_8113);
        @(negedge clk);
        chk("i2_pc", pc, 32'h8);
        chk("i2_instret", instret, 32'h2);
        // signed byte load at 0x103
        hart_load = 1; memaddr = 32'h103; memwidth = 2'd0; memsext = 1; nextpc = 32'hC;
        exp_q.push_back('{1'b0, 32'h8, 4'hF, 32'h0});
        exp_q.push_back('{1'b0, 32'h100, 4'b1000, 32'h0});
        serve(0, 32'h1030_0083);
        chk("lb_exec_commit", {31'h0, commit}, 32'h0);
        @(negedge clk);
        memaddr = 32'hDEAD_BEE0;
        serve(0, 32'h80FF_FFFF);
        chk("lb_commit", {31'h0, commit}, 32'h1);
        chk("lb_data", memrdata, 32'hFFFF_FF80);
        hart_load = 0; memsext = 0;
        @(negedge clk);
        chk("lb_pc", pc, 32'hC);
        chk("lb_instret", instret, 32'h3);
        // half store at 0x202, one data wait
        memw = 1; memaddr = 32'h202; memwidth = 2'd1; memwdata = 32'h1234_ABCD; nextpc = 32'h10;
        exp_q.push_back('{1'b0, 32'hC, 4'hF, 32'h0});
        exp_q.push_back('{1'b1, 32'h200, 4'b1100, 32'hABCD_ABCD});
        serve(0, 32'h0010_1123);
        chk("sh_exec_commit", {31'h0, commit}, 32'h0);
        serve(1, 32'h5555_5555);
        chk("sh_commit", {31'h0, commit}, 32'h1);
        chk("sh_memrdata_kept", memrdata, 32'hFFFF_FF80);
        memw = 0;
        @(negedge clk);
        chk("sh_pc", pc, 32'h10);
        chk("sh_instret", instret, 32'h4);
        // run dropped during EXEC
        nextpc = 32'h14;
        exp_q.push_back('{1'b0, 32'h10, 4'hF, 32'h0});
        serve(0, 32'h0050_0093);
        run = 0;
        chk("idle_commit", {31'h0, commit}, 32'h1);
        @(negedge clk);
        chk("idle_insn", insn, 32'h0000_0013);
        chk("idle_pc", pc, 32'h14);
        chk("idle_instret", instret, 32'h5);
        @(negedge clk);
        chk("idle_req", {31'h0, bus_req}, 32'h0);
        run = 1;
        @(negedge clk);
        // misaligned word load at 0x101
        hart_load = 1; memaddr = 32'h101; memwidth = 2'd2; nextpc = 32'h18;
        exp_q.push_back('{1'b0, 32'h14, 4'hF, 32'h0});
        serve(0, 32'h1010_2083);
        chk("mis_exec_commit", {31'h0, commit}, 32'h0);
`ifdef HART_SEQ_MISALIGN_CHECK_EN
        chk("mis_exec_req", {31'h0, bus_req}, 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("halt_fault", {31'h0, fault}, 32'h1);
            chk("halt_req", {31'h0, bus_req}, 32'h0);
            chk("halt_commit", {31'h0, commit}, 32'h0);
        end
`else
        exp_q.push_back('{1'b0, 32'h100, 4'b1110, 32'h0});
        serve(0, 32'hAABB_CCDD);
        chk("mis_commit", {31'h0, commit}, 32'h1);
        chk("mis_data", memrdata, 32'h00AA_BBCC);
        chk("mis_fault", {31'h0, fault}, 32'h0);
        @(negedge clk);
        chk("mis_pc", pc, 32'h18);
`endif
        hart_load = 0;
        #2 reset = 1;
        #1 chk("rst2_fault", {31'h0, fault}, 32'h0);
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_req", {31'h0, bus_req}, 32'h0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        // reset pulsed while a data transfer is pending
        hart_load = 1; memaddr = 32'h300; memwidth = 2'd2; nextpc = 32'h4;
        exp_q.push_back('{1'b0, 32'h0, 4'hF, 32'h0});
        serve(0, 32'h3000_2083);
        @(negedge clk);
        chk("data_req", {31'h0, bus_req}, 32'h1);
        chk("data_addr", bus_addr, 32'h300);
        #2 reset = 1;
        #1 chk("abort_req", {31'h0, bus_req}, 32'h0);
        chk("abort_pc", pc, 32'h0);
        chk("abort_commit", {31'h0, commit}, 32'h0);
        chk("abort_instret", instret, 32'h0);
        @(negedge clk);
        reset = 0; hart_load = 0;
        chk("q_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
